// File: rtl/combat_resolver.sv
// Two-player combat state: health, shield, attack sequencing and hit resolution.
// Optional macro COMBAT_CHIP_DAMAGE_EN: blocked hits also remove 1 health.
module combat_resolver #(
  parameter int MAX_HEALTH      = 10,
  parameter int MAX_SHIELD      = 10,
  parameter int DAMAGE          = 2,
  parameter int CHAR_WIDTH      = 80,
  parameter int ACTIVE_FRAMES   = 6,
  parameter int COOLDOWN_FRAMES = 12,
  parameter int REGEN_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       frame_tick,
  input  logic [9:0] p1_x,
  input  logic [9:0] p2_x,
  input  logic [6:0] p1_action,
  input  logic [6:0] p2_action,
  output logic [3:0] p1_health,
  output logic [3:0] p2_health,
  output logic [3:0] p1_shield,
  output logic [3:0] p2_shield,
  output logic       p1_attack_grant,
  output logic       p2_attack_grant,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    COOL
  } st_t;

  localparam logic [3:0]  HP_MAX  = 4'(MAX_HEALTH);
  localparam logic [3:0]  SH_MAX  = 4'(MAX_SHIELD);
  localparam logic [3:0]  DMG     = 4'(DAMAGE);
  localparam logic [10:0] CW      = 11'(CHAR_WIDTH);
  localparam logic [7:0]  ACT_LD  = 8'(ACTIVE_FRAMES - 1);
  localparam logic [7:0]  COOL_LD = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0]  RG_TOP  = 8'(REGEN_FRAMES - 1);

  function automatic logic [3:0] sat_sub(input logic [3:0] a,
                                         input logic [3:0] b);
    return (a > b) ? a - b : 4'd0;
  endfunction

  logic [9:0] x   [2];
  logic       dir [2];
  logic       atk [2];
  logic       shd [2];

  assign x[0]   = p1_x;
  assign x[1]   = p2_x;
  assign dir[0] = p1_action[6];
  assign dir[1] = p2_action[6];
  assign atk[0] = p1_action[3];
  assign atk[1] = p2_action[3];
  assign shd[0] = p1_action[2];
  assign shd[1] = p2_action[2];

  logic unused_action;
  assign unused_action = ^{p1_action[5:4], p1_action[1:0],
                           p2_action[5:4], p2_action[1:0]};

  st_t        st_q  [2];
  st_t        st_d  [2];
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];
  logic       gnt_q [2];
  logic       gnt_d [2];
  logic [3:0] hp_q  [2];
  logic [3:0] hp_d  [2];
  logic [3:0] sh_q  [2];
  logic [3:0] sh_d  [2];
  logic [7:0] rg_q  [2];
  logic [7:0] rg_d  [2];
  logic       go_q;
  logic       go_d;
  logic [1:0] win_q;
  logic [1:0] win_d;

  logic [10:0] dx;
  logic        contact;
  logic        start  [2];
  logic        facing [2];
  logic        hit    [2];

  assign dx = (p1_x >= p2_x) ? ({1'b0, p1_x} - {1'b0, p2_x})
                             : ({1'b0, p2_x} - {1'b0, p1_x});
  assign contact = dx < CW;

  // hit[i] means player i lands a hit on the other player
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      start[i]  = (st_q[i] == IDLE) && atk[i] && !shd[i] && !go_q;
      facing[i] = dir[i] ? (x[i] > x[1-i]) : (x[i] < x[1-i]);
      hit[i]    = start[i] && contact && facing[i];
    end
  end

  always_comb begin
    go_d  = go_q;
    win_d = win_q;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      gnt_d[i] = gnt_q[i];
      hp_d[i]  = hp_q[i];
      sh_d[i]  = sh_q[i];
      rg_d[i]  = rg_q[i];
    end

    if (frame_tick && !go_q) begin
      for (int i = 0; i < 2; i++) begin
        unique case (st_q[i])
          IDLE: begin
            if (start[i]) begin
              st_d[i]  = ACTIVE;
              cnt_d[i] = ACT_LD;
              gnt_d[i] = 1'b1;
            end
          end
          ACTIVE: begin
            if (cnt_q[i] == 8'd0) begin
              st_d[i]  = COOL;
              cnt_d[i] = COOL_LD;
              gnt_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          COOL: begin
            if (cnt_q[i] == 8'd0) begin
              st_d[i] = IDLE;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          default: begin
            st_d[i]  = IDLE;
            cnt_d[i] = 8'd0;
            gnt_d[i] = 1'b0;
          end
        endcase

        // a hit on this player takes priority over regen
        if (hit[1-i]) begin
          rg_d[i] = 8'd0;
          if (shd[i] && sh_q[i] != 4'd0) begin
            sh_d[i] = sh_q[i] - 4'd1;
`ifdef COMBAT_CHIP_DAMAGE_EN
            hp_d[i] = sat_sub(hp_q[i], 4'd1);
`endif
          end else begin
            hp_d[i] = sat_sub(hp_q[i], DMG);
          end
        end else if (shd[i]) begin
          rg_d[i] = 8'd0;
        end else if (sh_q[i] < SH_MAX) begin
          if (rg_q[i] == RG_TOP) begin
            sh_d[i] = sh_q[i] + 4'd1;
            rg_d[i] = 8'd0;
          end else begin
            rg_d[i] = rg_q[i] + 8'd1;
          end
        end
      end

      if (hp_d[0] == 4'd0 || hp_d[1] == 4'd0) begin
        go_d  = 1'b1;
        win_d = {hp_d[0] == 4'd0, hp_d[1] == 4'd0};
        for (int i = 0; i < 2; i++) begin
          st_d[i]  = IDLE;
          cnt_d[i] = 8'd0;
          gnt_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      go_q  <= 1'b0;
      win_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= 8'd0;
        gnt_q[i] <= 1'b0;
        hp_q[i]  <= HP_MAX;
        sh_q[i]  <= SH_MAX;
        rg_q[i]  <= 8'd0;
      end
    end else begin
      go_q  <= go_d;
      win_q <= win_d;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        gnt_q[i] <= gnt_d[i];
        hp_q[i]  <= hp_d[i];
        sh_q[i]  <= sh_d[i];
        rg_q[i]  <= rg_d[i];
      end
    end
  end

  assign p1_health       = hp_q[0];
  assign p2_health       = hp_q[1];
  assign p1_shield       = sh_q[0];
  assign p2_shield       = sh_q[1];
  assign p1_attack_grant = gnt_q[0];
  assign p2_attack_grant = gnt_q[1];
  assign game_over       = go_q;
  assign winner          = win_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Scoreboard bench for combat_resolver: directed frame sequences,
// expected outputs queued per frame_tick and checked by a monitor.
module tb_combat_resolver;

  logic       clk;
  logic       rst_l;
  logic       frame_tick;
  logic [9:0] p1_x;
  logic [9:0] p2_x;
  logic [6:0] p1_action;
  logic [6:0] p2_action;
  logic [3:0] p1_health;
  logic [3:0] p2_health;
  logic [3:0] p1_shield;
  logic [3:0] p2_shield;
  logic       p1_attack_grant;
  logic       p2_attack_grant;
  logic       game_over;
  logic [1:0] winner;

  combat_resolver dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .frame_tick      (frame_tick),
    .p1_x            (p1_x),
    .p2_x            (p2_x),
    .p1_action       (p1_action),
    .p2_action       (p2_action),
    .p1_health       (p1_health),
    .p2_health       (p2_health),
    .p1_shield       (p1_shield),
    .p2_shield       (p2_shield),
    .p1_attack_grant (p1_attack_grant),
    .p2_attack_grant (p2_attack_grant),
    .game_over       (game_over),
    .winner          (winner)
  );

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h2;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       g1;
    logic       g2;
    logic       go;
    logic [1:0] win;
    logic       cg;
  } exp_t;

  localparam exp_t RST_EXP = '{h1: 4'd10, h2: 4'd10, s1: 4'd10,
                               s2: 4'd10, g1: 1'b0, g2: 1'b0,
                               go: 1'b0, win: 2'd0, cg: 1'b1};

  int   checks;
  int   failures;
  exp_t e;
  exp_t sb[$];
  logic ft_seen;
  int   tick_no;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observe();
    exp_t o;
    o.h1  = p1_health;
    o.h2  = p2_health;
    o.s1  = p1_shield;
    o.s2  = p2_shield;
    o.g1  = p1_attack_grant;
    o.g2  = p2_attack_grant;
    o.go  = game_over;
    o.win = winner;
    o.cg  = 1'b1;
    return o;
  endfunction

  task automatic chk(input string name, input exp_t act, input exp_t exp);
    exp_t a;
    exp_t x;
    a = act;
    x = exp;
    if (!x.cg) begin
      a.g1 = 1'b0;
      a.g2 = 1'b0;
      x.g1 = 1'b0;
      x.g2 = 1'b0;
    end
    a.cg = 1'b1;
    x.cg = 1'b1;
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s: got h1=%0d h2=%0d s1=%0d s2=%0d g=%b%b go=%b win=%0d, expected h1=%0d h2=%0d s1=%0d s2=%0d g=%b%b go=%b win=%0d",
               name, a.h1, a.h2, a.s1, a.s2, a.g1, a.g2, a.go, a.win,
               x.h1, x.h2, x.s1, x.s2, x.g1, x.g2, x.go, x.win);
    end
  endtask

  always @(posedge clk) ft_seen <= frame_tick;

  // monitor: outputs are valid one clk after each frame_tick edge
  always @(negedge clk) begin
    if (ft_seen === 1'b1) begin
      tick_no++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty at tick %0d", tick_no);
      end else begin
        chk($sformatf("tick%0d", tick_no), observe(), sb.pop_front());
      end
    end
  end

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  // one attack: request tick, 5 more grant ticks, then 13 ticks back to IDLE
  task automatic swing(input logic [6:0] a1, input logic [6:0] a2);
    p1_action = a1;
    p2_action = a2;
    e.g1 = a1[3];
    e.g2 = a2[3];
    ticks(1);
    p1_action = a1 & ~7'h08;
    p2_action = a2 & ~7'h08;
    ticks(5);
    e.g1 = 1'b0;
    e.g2 = 1'b0;
    ticks(13);
  endtask

  task automatic do_reset();
    p1_action = 7'h00;
    p2_action = 7'h00;
    rst_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    e = RST_EXP;
    @(negedge clk);
    chk("reset_state", observe(), e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    tick_no    = 0;
    rst_l      = 1'b0;
    frame_tick = 1'b0;
    p1_x       = 10'd100;
    p2_x       = 10'd150;
    p1_action  = 7'h00;
    p2_action  = 7'h00;
    e          = RST_EXP;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    chk("reset_state", observe(), e);
    repeat (3) @(negedge clk);
    chk("no_tick_hold", observe(), e);

    // P1 facing right hits P2; request during cooldown ignored
    p1_action = 7'h08;
    e.g1 = 1'b1;
    e.h2 = 4'd8;
    ticks(1);
    p1_action = 7'h00;
    ticks(5);
    e.g1 = 1'b0;
    ticks(1);
    p1_action = 7'h08;
    ticks(12);
    p1_action = 7'h00;

    // P1 facing left: grant but no hit
    swing(7'h48, 7'h00);

    // P2 blocks with shield up
    e.s2 = 4'd9;
`ifdef COMBAT_CHIP_DAMAGE_EN
    e.h2 = 4'd7;
`endif
    swing(7'h08, 7'h04);

`ifndef COMBAT_CHIP_DAMAGE_EN
    // drain P2 shield, then a shielded hit with empty shield, then regen
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      e.s2 = 4'(10 - k);
      swing(7'h08, 7'h04);
    end
    e.h2 = 4'd8;
    swing(7'h08, 7'h04);
    p2_action = 7'h00;
    ticks(59);
    e.s2 = 4'd1;
    ticks(1);
    p2_action = 7'h04;
    ticks(100);
`endif

    // trades down to a draw
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      e.h1 = 4'(10 - 2 * k);
      e.h2 = 4'(10 - 2 * k);
      swing(7'h08, 7'h48);
    end
    p1_action = 7'h08;
    p2_action = 7'h48;
    e.h1  = 4'd0;
    e.h2  = 4'd0;
    e.go  = 1'b1;
    e.win = 2'd3;
    e.cg  = 1'b0;
    ticks(1);
    e.cg = 1'b1;
    e.g1 = 1'b0;
    e.g2 = 1'b0;
    ticks(3);
    p1_action = 7'h00;
    p2_action = 7'h00;

    // async reset in the middle of an active window
    do_reset();
    p1_action = 7'h08;
    e.g1 = 1'b1;
    e.h2 = 4'd8;
    ticks(1);
    p1_action = 7'h00;
    ticks(2);
    #3;
    rst_l = 1'b0;
    #1;
    chk("async_reset", observe(), RST_EXP);
    @(negedge clk);
    rst_l = 1'b1;
    e = RST_EXP;
    ticks(2);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
